// File: rtl/svga_timing.sv
// Raster timing generator: 800x525-style scan counters, delayed sync/blank flags and
// same-cycle coordinates for a 512x384 text/graphics window inside the visible area.
module svga_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int WIN_X0     = 64,
    parameter int WIN_Y0     = 48,
    parameter int PIPE_DELAY = 4
) (
    input  logic       pixel_clock,
    input  logic       reset,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       video_on,
    output logic       show_border,
    output logic [6:0] char_column,
    output logic [6:0] char_line,
    output logic [4:0] subchar_line,
    output logic [3:0] subchar_pixel,
    output logic [8:0] graph_pixel,
    output logic [9:0] graph_line_2x,
    output logic [9:0] graph_line_3x,
    output logic       frame_tick
);
    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HSPAN = (HT > WIN_X0 + 512) ? HT : WIN_X0 + 512;
    localparam int VSPAN = (VT > WIN_Y0 + 384) ? VT : WIN_Y0 + 384;
    localparam int HW    = $clog2(HSPAN + 1);
    localparam int VW    = $clog2(VSPAN + 1);
    localparam int PW    = (PIPE_DELAY > 0) ? PIPE_DELAY : 1;

    localparam logic [HW-1:0] L_H_ONE  = HW'(1);
    localparam logic [HW-1:0] L_H_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] L_H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] L_HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] L_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] L_WX_BEG = HW'(WIN_X0);
    localparam logic [HW-1:0] L_WX_END = HW'(WIN_X0 + 512);
    localparam logic [VW-1:0] L_V_ONE  = VW'(1);
    localparam logic [VW-1:0] L_V_LAST = VW'(VT - 1);
    localparam logic [VW-1:0] L_V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] L_VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] L_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] L_WY_BEG = VW'(WIN_Y0);
    localparam logic [VW-1:0] L_WY_END = VW'(WIN_Y0 + 384);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;
    logic          r_run;
    logic          w_vwin_next;
    logic          w_win_next;
    logic          w_vo_next;
    logic          w_hs_next;
    logic          w_vs_next;
    logic          w_line_start;

    logic          r_frame_tick;
    logic          r_show_border;
    logic [8:0]    r_gp;
    logic          r_hs_raw;
    logic          r_vs_raw;
    logic          r_vo_raw;

    logic [9:0]    r_gl2;
    logic [9:0]    r_gl3;
    logic [1:0]    r_phase;
    logic [4:0]    r_sl;
    logic [6:0]    r_cl;

    logic [PW-1:0] r_hs_pipe;
    logic [PW-1:0] r_vs_pipe;
    logic [PW-1:0] r_vo_pipe;

    // Next raster position; the first cycle after reset holds (0,0) so the frame starts there.
    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (!r_run) begin
            w_h_next = '0;
            w_v_next = '0;
        end else if (r_h == L_H_LAST) begin
            w_h_next = '0;
            if (r_v == L_V_LAST) begin
                w_v_next = '0;
            end else begin
                w_v_next = r_v + L_V_ONE;
            end
        end else begin
            w_h_next = r_h + L_H_ONE;
        end
    end

    assign w_line_start = (w_h_next == '0);
    assign w_vwin_next  = (w_v_next >= L_WY_BEG) && (w_v_next < L_WY_END);
    assign w_win_next   = w_vwin_next && (w_h_next >= L_WX_BEG) && (w_h_next < L_WX_END);
    assign w_vo_next    = (w_h_next < L_H_ACT) && (w_v_next < L_V_ACT);
    assign w_hs_next    = (w_h_next >= L_HS_BEG) && (w_h_next < L_HS_END);
    assign w_vs_next    = (w_v_next >= L_VS_BEG) && (w_v_next < L_VS_END);

    // Scan counters plus per-pixel flags registered against the position they describe.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_run         <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_tick  <= 1'b0;
            r_show_border <= 1'b0;
            r_gp          <= 9'd0;
            r_hs_raw      <= 1'b0;
            r_vs_raw      <= 1'b0;
            r_vo_raw      <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_frame_tick  <= (w_h_next == '0) && (w_v_next == '0);
            r_show_border <= w_vo_next && !w_win_next;
            r_gp          <= w_win_next ? 9'(w_h_next - L_WX_BEG) : 9'd0;
            r_hs_raw      <= w_hs_next;
            r_vs_raw      <= w_vs_next;
            r_vo_raw      <= w_vo_next;
        end
    end

    // Window line counters step once per line; the 8/3 scale adds 2,3,3 via a mod-3 phase.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_gl2   <= 10'd0;
            r_gl3   <= 10'd0;
            r_phase <= 2'd0;
            r_sl    <= 5'd0;
            r_cl    <= 7'd0;
        end else if (w_line_start) begin
            if (!w_vwin_next || (w_v_next == L_WY_BEG)) begin
                r_gl2   <= 10'd0;
                r_gl3   <= 10'd0;
                r_phase <= 2'd0;
                r_sl    <= 5'd0;
                r_cl    <= 7'd0;
            end else begin
                r_gl2   <= r_gl2 + 10'd1;
                r_gl3   <= r_gl3 + ((r_phase == 2'd0) ? 10'd2 : 10'd3);
                r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
                if (r_sl == 5'd23) begin
                    r_sl <= 5'd0;
                    r_cl <= r_cl + 7'd1;
                end else begin
                    r_sl <= r_sl + 5'd1;
                end
            end
        end
    end

    // Delay line aligning sync/blank with the downstream pixel pipeline.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_vo_pipe <= '0;
        end else begin
            r_hs_pipe[0] <= r_hs_raw;
            r_vs_pipe[0] <= r_vs_raw;
            r_vo_pipe[0] <= r_vo_raw;
            for (int i = 1; i < PW; i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
                r_vo_pipe[i] <= r_vo_pipe[i-1];
            end
        end
    end

    assign hsync_n       = (PIPE_DELAY == 0) ? !r_hs_raw : !r_hs_pipe[PW-1];
    assign vsync_n       = (PIPE_DELAY == 0) ? !r_vs_raw : !r_vs_pipe[PW-1];
    assign video_on      = (PIPE_DELAY == 0) ?  r_vo_raw :  r_vo_pipe[PW-1];
    assign show_border   = r_show_border;
    assign frame_tick    = r_frame_tick;
    assign graph_pixel   = r_gp;
    assign subchar_pixel = r_gp[3:0];
    assign char_column   = {2'b00, r_gp[8:4]};
    assign graph_line_2x = r_gl2;
    assign graph_line_3x = r_gl3;
    assign subchar_line  = r_sl;
    assign char_line     = r_cl;
endmodule

// File: tb/tb_svga_timing.sv
// Bench for svga_timing: a wide-line instance and a tall-frame instance, each with a
// 9600-cycle frame, checked against a cycle-index model, a point table and timing sequences.
module tb_svga_timing;
    localparam int F_SB = 0, F_GP = 1, F_CC = 2, F_SP = 3, F_CL = 4;
    localparam int F_SL = 5, F_GL2 = 6, F_GL3 = 7, F_FT = 8;
    localparam int W_PD  = 4;
    localparam int T_PD  = 2;
    localparam int FRAME = 9600;

    typedef struct { int dut; int v; int h; int fld; int exp; } vec_t;
    typedef struct packed { logic hs_n; logic vs_n; logic vo; } sync_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       w_hs_n, w_vs_n, w_vo, w_sb, w_ft;
    logic [6:0] w_cc, w_cl;
    logic [4:0] w_sl;
    logic [3:0] w_sp;
    logic [8:0] w_gp;
    logic [9:0] w_gl2, w_gl3;
    logic       t_hs_n, t_vs_n, t_vo, t_sb, t_ft;
    logic [6:0] t_cc, t_cl;
    logic [4:0] t_sl;
    logic [3:0] t_sp;
    logic [8:0] t_gp;
    logic [9:0] t_gl2, t_gl3;

    svga_timing #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .WIN_X0(64), .WIN_Y0(2), .PIPE_DELAY(W_PD)
    ) u_wide (
        .pixel_clock(clk), .reset(rst), .hsync_n(w_hs_n), .vsync_n(w_vs_n),
        .video_on(w_vo), .show_border(w_sb), .char_column(w_cc), .char_line(w_cl),
        .subchar_line(w_sl), .subchar_pixel(w_sp), .graph_pixel(w_gp),
        .graph_line_2x(w_gl2), .graph_line_3x(w_gl3), .frame_tick(w_ft)
    );

    svga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(392), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .WIN_X0(4), .WIN_Y0(4), .PIPE_DELAY(T_PD)
    ) u_tall (
        .pixel_clock(clk), .reset(rst), .hsync_n(t_hs_n), .vsync_n(t_vs_n),
        .video_on(t_vo), .show_border(t_sb), .char_column(t_cc), .char_line(t_cl),
        .subchar_line(t_sl), .subchar_pixel(t_sp), .graph_pixel(t_gp),
        .graph_line_2x(t_gl2), .graph_line_3x(t_gl3), .frame_tick(t_ft)
    );

    int    n_checks = 0;
    int    n_fail = 0;
    int    n_stream_fail = 0;
    int    t = 0;
    bit    running = 1'b0;
    bit    table_on = 1'b0;
    vec_t  tbl[$];
    sync_t q_w[$];
    sync_t q_t[$];

    function automatic bit check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int hpos(input int dut);
        return (dut == 0) ? t % 800 : t % 24;
    endfunction

    function automatic int vpos(input int dut);
        return (dut == 0) ? (t / 800) % 12 : (t / 24) % 400;
    endfunction

    function automatic sync_t raw_model(input int dut);
        int    h;
        int    v;
        sync_t s;
        h = hpos(dut);
        v = vpos(dut);
        if (dut == 0) begin
            s.hs_n = !(h >= 656 && h < 752);
            s.vs_n = !(v >= 9 && v < 11);
            s.vo   = (h < 640) && (v < 8);
        end else begin
            s.hs_n = !(h >= 18 && h < 22);
            s.vs_n = !(v >= 394 && v < 396);
            s.vo   = (h < 16) && (v < 392);
        end
        return s;
    endfunction

    function automatic string fname(input int fld);
        case (fld)
            F_SB:    return "show_border";
            F_GP:    return "graph_pixel";
            F_CC:    return "char_column";
            F_SP:    return "subchar_pixel";
            F_CL:    return "char_line";
            F_SL:    return "subchar_line";
            F_GL2:   return "graph_line_2x";
            F_GL3:   return "graph_line_3x";
            F_FT:    return "frame_tick";
            default: return "unknown";
        endcase
    endfunction

    function automatic int field_val(input int dut, input int fld);
        case (fld)
            F_SB:    return (dut == 0) ? int'(w_sb)  : int'(t_sb);
            F_GP:    return (dut == 0) ? int'(w_gp)  : int'(t_gp);
            F_CC:    return (dut == 0) ? int'(w_cc)  : int'(t_cc);
            F_SP:    return (dut == 0) ? int'(w_sp)  : int'(t_sp);
            F_CL:    return (dut == 0) ? int'(w_cl)  : int'(t_cl);
            F_SL:    return (dut == 0) ? int'(w_sl)  : int'(t_sl);
            F_GL2:   return (dut == 0) ? int'(w_gl2) : int'(t_gl2);
            F_GL3:   return (dut == 0) ? int'(w_gl3) : int'(t_gl3);
            F_FT:    return (dut == 0) ? int'(w_ft)  : int'(t_ft);
            default: return -1;
        endcase
    endfunction

    task automatic stream_check();
        sync_t e;
        q_w.push_back(raw_model(0));
        q_t.push_back(raw_model(1));
        if (n_stream_fail < 20) begin
            e = q_w.pop_front();
            if (!check("wide_hsync_n", int'(w_hs_n), int'(e.hs_n))) n_stream_fail++;
            if (!check("wide_vsync_n", int'(w_vs_n), int'(e.vs_n))) n_stream_fail++;
            if (!check("wide_video_on", int'(w_vo), int'(e.vo))) n_stream_fail++;
            if (!check("wide_frame_tick", int'(w_ft), int'(t % FRAME == 0))) n_stream_fail++;
            e = q_t.pop_front();
            if (!check("tall_hsync_n", int'(t_hs_n), int'(e.hs_n))) n_stream_fail++;
            if (!check("tall_vsync_n", int'(t_vs_n), int'(e.vs_n))) n_stream_fail++;
            if (!check("tall_video_on", int'(t_vo), int'(e.vo))) n_stream_fail++;
            if (!check("tall_frame_tick", int'(t_ft), int'(t % FRAME == 0))) n_stream_fail++;
        end else begin
            e = q_w.pop_front();
            e = q_t.pop_front();
        end
    endtask

    task automatic table_check();
        foreach (tbl[i]) begin
            if (tbl[i].v == vpos(tbl[i].dut) && tbl[i].h == hpos(tbl[i].dut)) begin
                void'(check($sformatf("%s_%s_v%0d_h%0d", (tbl[i].dut == 0) ? "wide" : "tall",
                                      fname(tbl[i].fld), tbl[i].v, tbl[i].h),
                            field_val(tbl[i].dut, tbl[i].fld), tbl[i].exp));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (running) begin
            t++;
            stream_check();
            if (table_on) table_check();
        end
    endtask

    task automatic start_run();
        sync_t idle;
        idle = 3'b110;
        q_w.delete();
        q_t.delete();
        repeat (W_PD) q_w.push_back(idle);
        repeat (T_PD) q_t.push_back(idle);
        t = -1;
        running = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        void'(check({tag, "_wide_hsync_n"}, int'(w_hs_n), 1));
        void'(check({tag, "_wide_vsync_n"}, int'(w_vs_n), 1));
        void'(check({tag, "_wide_video_on"}, int'(w_vo), 0));
        void'(check({tag, "_tall_hsync_n"}, int'(t_hs_n), 1));
        void'(check({tag, "_tall_vsync_n"}, int'(t_vs_n), 1));
        void'(check({tag, "_tall_video_on"}, int'(t_vo), 0));
        for (int d = 0; d < 2; d++) begin
            for (int f = F_SB; f <= F_FT; f++) begin
                void'(check($sformatf("%s_%s_%s", tag, (d == 0) ? "wide" : "tall", fname(f)),
                            field_val(d, f), 0));
            end
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return w_hs_n;
            1:       return w_vs_n;
            default: return w_ft;
        endcase
    endfunction

    task automatic wait_level(input int which, input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (sig(which) != lvl && n < budget) begin
            tick();
            n++;
        end
        void'(check({name, "_reached"}, int'(sig(which)), int'(lvl)));
    endtask

    initial begin
        int t0;
        tbl.push_back('{0, 2, 63, F_SB, 1});   tbl.push_back('{0, 2, 64, F_SB, 0});
        tbl.push_back('{0, 2, 64, F_GP, 0});   tbl.push_back('{0, 2, 64, F_CC, 0});
        tbl.push_back('{0, 2, 64, F_SP, 0});   tbl.push_back('{0, 2, 576, F_SB, 1});
        tbl.push_back('{0, 2, 576, F_GP, 0});  tbl.push_back('{0, 2, 80, F_CC, 1});
        tbl.push_back('{0, 2, 80, F_SP, 0});   tbl.push_back('{0, 2, 575, F_GP, 511});
        tbl.push_back('{0, 2, 575, F_CC, 31}); tbl.push_back('{0, 2, 575, F_SP, 15});
        tbl.push_back('{0, 3, 100, F_GP, 36}); tbl.push_back('{0, 3, 100, F_CC, 2});
        tbl.push_back('{0, 3, 100, F_SP, 4});  tbl.push_back('{0, 3, 100, F_GL2, 1});
        tbl.push_back('{0, 3, 100, F_GL3, 2}); tbl.push_back('{0, 7, 64, F_GL3, 13});
        tbl.push_back('{0, 1, 100, F_SB, 1});  tbl.push_back('{0, 1, 100, F_GP, 0});
        tbl.push_back('{0, 1, 100, F_GL2, 0}); tbl.push_back('{0, 8, 100, F_SB, 0});
        tbl.push_back('{0, 2, 700, F_SB, 0});  tbl.push_back('{0, 2, 700, F_GP, 0});
        tbl.push_back('{0, 0, 0, F_FT, 1});    tbl.push_back('{0, 0, 1, F_FT, 0});
        tbl.push_back('{0, 0, 0, F_SB, 1});
        tbl.push_back('{1, 4, 4, F_GL3, 0});   tbl.push_back('{1, 4, 4, F_GL2, 0});
        tbl.push_back('{1, 4, 4, F_SL, 0});    tbl.push_back('{1, 4, 4, F_CL, 0});
        tbl.push_back('{1, 4, 4, F_GP, 0});    tbl.push_back('{1, 5, 0, F_GL3, 2});
        tbl.push_back('{1, 6, 10, F_GL3, 5});  tbl.push_back('{1, 6, 10, F_GP, 6});
        tbl.push_back('{1, 6, 2, F_GP, 0});    tbl.push_back('{1, 7, 3, F_GL3, 8});
        tbl.push_back('{1, 8, 3, F_GL3, 10});  tbl.push_back('{1, 9, 3, F_GL3, 13});
        tbl.push_back('{1, 10, 3, F_GL3, 16}); tbl.push_back('{1, 27, 5, F_CL, 0});
        tbl.push_back('{1, 27, 5, F_SL, 23});  tbl.push_back('{1, 28, 5, F_CL, 1});
        tbl.push_back('{1, 28, 5, F_SL, 0});   tbl.push_back('{1, 387, 5, F_CL, 15});
        tbl.push_back('{1, 387, 5, F_SL, 23}); tbl.push_back('{1, 387, 5, F_GL3, 1021});
        tbl.push_back('{1, 387, 5, F_GL2, 383}); tbl.push_back('{1, 388, 5, F_CL, 0});
        tbl.push_back('{1, 388, 5, F_SL, 0});  tbl.push_back('{1, 388, 5, F_GL3, 0});
        tbl.push_back('{1, 388, 5, F_GL2, 0}); tbl.push_back('{1, 388, 5, F_SB, 1});
        tbl.push_back('{1, 3, 23, F_GL3, 0});  tbl.push_back('{1, 3, 23, F_GL2, 0});
        tbl.push_back('{1, 0, 0, F_GL3, 0});   tbl.push_back('{1, 0, 0, F_CL, 0});

        rst = 1'b1;
        repeat (5) tick();
        check_reset("init");

        rst = 1'b0;
        start_run();
        table_on = 1'b1;
        while (t < 2 * FRAME + 5 * 800 + 300) tick();
        table_on = 1'b0;

        // abandon the frame mid-line and restart
        rst = 1'b1;
        running = 1'b0;
        repeat (3) tick();
        check_reset("midreset");
        rst = 1'b0;
        start_run();
        tick();
        void'(check("post_reset_wide_frame_tick", int'(w_ft), 1));
        void'(check("post_reset_tall_frame_tick", int'(t_ft), 1));
        void'(check("post_reset_wide_show_border", int'(w_sb), 1));
        void'(check("post_reset_tall_graph_line_3x", int'(t_gl3), 0));

        wait_level(0, 1'b0, 2000, "hs_fall1");
        void'(check("hs_first_fall_cycle", t, 656 + W_PD));
        t0 = t;
        wait_level(0, 1'b1, 200, "hs_rise");
        void'(check("hs_low_width", t - t0, 96));
        wait_level(0, 1'b0, 1000, "hs_fall2");
        void'(check("hs_period", t - t0, 800));
        wait_level(1, 1'b0, 9000, "vs_fall");
        void'(check("vs_fall_cycle", t, 9 * 800 + W_PD));
        t0 = t;
        wait_level(1, 1'b1, 2000, "vs_rise");
        void'(check("vs_low_width", t - t0, 1600));
        wait_level(2, 1'b1, 2000, "ft_next");
        void'(check("frame_tick_period", t, FRAME));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
